ps2_wasd_decoder: RTL and testbench
===================================

Name: ps2_wasd_decoder

Overview:
- Upstream stage for the game top level: receives raw PS/2 keyboard frames and produces the held-key levels W, A, S, D that drive player movement.
- Synchronises ps2_clk/ps2_data into the system clock domain and deserialises 11-bit frames.
- Validates parity and framing, and tracks make/break (F0) and extended (E0) prefixes.
- Holds one level output per key until that key's break code arrives.

Parameters:
- TIMEOUT_CYCLES, 100000, clk cycles without a ps2_clk falling edge before a partial frame is abandoned (1 ms at 100 MHz).
- CODE_W, 8'h1D, scan code for W.
- CODE_A, 8'h1C, scan code for A.
- CODE_S, 8'h1B, scan code for S.
- CODE_D, 8'h23, scan code for D.

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  synchronous, active-high reset
- ps2_clk  input  1  raw PS/2 clock, asynchronous
- ps2_data  input  1  raw PS/2 data, asynchronous
- W  output  1  high while W is held
- A  output  1  high while A is held
- S  output  1  high while S is held
- D  output  1  high while D is held
- code  output  8  last accepted byte
- code_valid  output  1  one-cycle pulse when code updates
- frame_err  output  1  one-cycle pulse on parity, start or stop error, or on timeout

Behaviour:
- Reset (synchronous, active-high):
  - W, A, S, D, code_valid and frame_err = 0; code = 8'h00.
  - Bit counter = 0; break and ext flags = 0; timeout counter = 0.
  - Synchroniser flops = 1 (idle bus).
  - Reset asserted mid-frame discards the partial frame.
- Synchronisation: ps2_clk and ps2_data each pass through 2 flops. A falling edge (fall) is detected when the prior synced ps2_clk = 1 and the current synced ps2_clk = 0. Data is sampled from synced ps2_data in the fall cycle.
- Receive FSM:
  - IDLE: on fall with data = 0, go to SHIFT with bitcnt = 1. On fall with data = 1, stay in IDLE (glitch, no error).
  - SHIFT: each fall shifts the data bit into an 8-bit shift register, LSB first (bits 1..8), then latches the parity bit (bit 9), then checks the stop bit (bit 10).
  - CHECK (same clock as the 11th fall): stop bit must be 1 and data^parity must have odd parity over 9 bits.
    - Pass: accept the byte.
    - Fail: pulse frame_err.
    - Either way, return to IDLE.
- Timeout: in SHIFT, the counter increments each cycle without a fall and clears on each fall. When it reaches TIMEOUT_CYCLES-1: pulse frame_err, go to IDLE, clear break and ext flags. Keys are not changed.
- Accept path (registered at the edge ending the 11th-fall cycle):
  - Update code, pulse code_valid.
  - Then apply decode, in priority order:
    - byte = F0: set break; keys unchanged.
    - byte = E0: set ext; keys unchanged.
    - ext = 1: any other byte is ignored for keys; clear break and ext.
    - break = 1 and byte matches a key code: that key goes to 0; clear break.
    - break = 0 and byte matches a key code: that key goes to 1. Typematic repeats keep it at 1.
    - Non-matching byte: keys unchanged; clear break.
- A frame error clears break and ext, so a corrupted break sequence never latches a wrong state.
- Multiple keys may be held simultaneously; each key is an independent flag.
- Latency: keys, code and code_valid change 1 clk after the synchronised 11th falling edge, i.e. at most 4 clk after the raw 11th edge.
- code_valid and frame_err are never high in the same cycle.

Test Plan:
- Send frame 1D with correct odd parity (parity bit 1) -> code = 8'h1D, code_valid pulses once, W = 1, A/S/D = 0.
- With W held, send F0 then 1D -> two code_valid pulses (F0, 1D); W falls to 0 only after the 1D pulse.
- Send 1C, then 23, then E0 F0 1C -> after the 1C and 23 frames, A = 1 and D = 1. The E0 F0 1C sequence is extended and leaves A = 1, with ext and break cleared afterwards.
- Send 23 with its parity bit flipped -> frame_err pulses, code_valid stays 0, code is unchanged, D = 0. A following valid 23 sets D = 1.
- Send 5 bits and then stop toggling ps2_clk -> frame_err pulses TIMEOUT_CYCLES clk after the 5th edge. A subsequent full 1B frame sets S = 1.
- Assert rst for 1 cycle mid-frame while W = 1 -> all outputs = 0 on the next edge. The remaining bits of the aborted frame cause no code_valid pulse.

Source files
------------

// File: rtl/ps2_wasd_decoder.sv
// PS/2 keyboard receiver that turns make/break scan codes for W, A, S, D into held-key levels.
// Frames are synchronised, deserialised LSB first, checked for odd parity and stop bit, then decoded.
module ps2_wasd_decoder #(
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [7:0] CODE_W         = 8'h1D,
    parameter logic [7:0] CODE_A         = 8'h1C,
    parameter logic [7:0] CODE_S         = 8'h1B,
    parameter logic [7:0] CODE_D         = 8'h23
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       W,
    output logic       A,
    output logic       S,
    output logic       D,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int           TW    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t        state, state_nx;
    logic          clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
    logic          fall, bit_in;
    logic [3:0]    bitcnt;
    logic [TW-1:0] tcnt;
    logic [7:0]    shreg;
    logic          parity_bit;
    logic          brk, ext;
    logic [3:0]    keys;
    logic [3:0]    key_hit;
    logic          frame_done, frame_ok, frame_bad, timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_data;
            dat_s2   <= dat_s1;
        end
    end

    assign fall   = clk_prev & ~clk_s2;
    assign bit_in = dat_s2;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (fall && !bit_in) state_nx = SHIFT;
            SHIFT:   if (frame_done || timeout) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // The 11th fall is also the check cycle: the stop bit is on bit_in right now.
    always_comb begin
        frame_done = 1'b0;
        timeout    = 1'b0;
        if (state == SHIFT) begin
            frame_done = fall && (bitcnt == 4'd10);
            timeout    = !fall && (tcnt == TLAST);
        end
        frame_ok  = frame_done && bit_in && (^{shreg, parity_bit});
        frame_bad = (frame_done && !frame_ok) || timeout;
    end

    assign key_hit = {shreg == CODE_W, shreg == CODE_A, shreg == CODE_S, shreg == CODE_D};

    always_ff @(posedge clk) begin
        if (rst) begin
            bitcnt     <= 4'd0;
            tcnt       <= '0;
            shreg      <= 8'h00;
            parity_bit <= 1'b0;
            brk        <= 1'b0;
            ext        <= 1'b0;
            keys       <= 4'b0000;
            code       <= 8'h00;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            code_valid <= frame_ok;
            frame_err  <= frame_bad;

            if (state == SHIFT && !fall && !timeout) tcnt <= tcnt + TW'(1);
            else                                     tcnt <= '0;

            if (state == IDLE && fall && !bit_in) begin
                bitcnt <= 4'd1;
            end else if (state == SHIFT && fall) begin
                if (bitcnt <= 4'd8) shreg <= {bit_in, shreg[7:1]};
                if (bitcnt == 4'd9) parity_bit <= bit_in;
                bitcnt <= frame_done ? 4'd0 : bitcnt + 4'd1;
            end else if (timeout) begin
                bitcnt <= 4'd0;
            end

            if (frame_bad) begin
                brk <= 1'b0;
                ext <= 1'b0;
            end

            if (frame_ok) begin
                code <= shreg;
                if (shreg == 8'hF0) begin
                    brk <= 1'b1;
                end else if (shreg == 8'hE0) begin
                    ext <= 1'b1;
                end else if (ext) begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                end else begin
                    if (|key_hit) keys <= brk ? (keys & ~key_hit) : (keys | key_hit);
                    brk <= 1'b0;
                end
            end
        end
    end

    assign {W, A, S, D} = keys;

endmodule

// File: tb/tb_ps2_wasd_decoder.sv
// Bench for ps2_wasd_decoder: directed key scenarios plus random frames, scored against a byte-level key model.
module tb_ps2_wasd_decoder;
    localparam int T    = 300;
    localparam int HALF = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       W, A, S, D;
    logic [7:0] code;
    logic       code_valid, frame_err;

    ps2_wasd_decoder #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .W(W), .A(A), .S(S), .D(D),
        .code(code), .code_valid(code_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Expected event: {is_error, code, W, A, S, D}
    logic [12:0] exp_q[$];

    logic [7:0] key_codes[4] = '{8'h1D, 8'h1C, 8'h1B, 8'h23};
    logic [7:0] pool[8]      = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'hF0, 8'hE0, 8'h29, 8'h75};
    logic       m_brk = 1'b0, m_ext = 1'b0;
    logic [3:0] m_keys = 4'b0000;
    logic [7:0] m_code = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_brk = 1'b0; m_ext = 1'b0; m_keys = 4'b0000; m_code = 8'h00;
    endtask

    task automatic model_accept(input logic [7:0] b);
        m_code = b;
        if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_ext = 1'b1;
        else if (m_ext) begin
            m_brk = 1'b0; m_ext = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (b == key_codes[i]) m_keys[3-i] = !m_brk;
            m_brk = 1'b0;
        end
        exp_q.push_back({1'b0, m_code, m_keys});
    endtask

    task automatic model_error();
        m_brk = 1'b0; m_ext = 1'b0;
        exp_q.push_back({1'b1, m_code, m_keys});
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2 * HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input int corrupt);
        logic par, stp;
        par = ~^b;
        stp = 1'b1;
        if (corrupt == 1) par = ~par;
        if (corrupt == 2) stp = 1'b0;
        return {stp, par, b, 1'b0};
    endfunction

    // corrupt: 0 clean, 1 parity flipped, 2 stop bit low
    task automatic send_frame(input logic [7:0] b, input int corrupt);
        logic [10:0] f;
        f = make_frame(b, corrupt);
        if (corrupt == 0) model_accept(b);
        else              model_error();
        for (int i = 0; i < 11; i++) send_bit(f[i]);
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_code"}, code, 8'h00);
        check({tag, "_keys"}, {W, A, S, D}, 4'b0000);
        check({tag, "_code_valid"}, code_valid, 1'b0);
        check({tag, "_frame_err"}, frame_err, 1'b0);
    endtask

    // Monitor: every output event is matched against the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && (code_valid || frame_err)) begin
            check("valid_err_exclusive", code_valid & frame_err, 1'b0);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_event: got cv=%b fe=%b code=%h required no event", code_valid, frame_err, code);
            end else begin
                check("event", {frame_err, code, W, A, S, D}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] f;
        int cnt;

        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        // Press W, then release with F0 1D
        send_frame(8'h1D, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h1D, 0);

        // A and D held together; extended E0 F0 1C must not release A
        send_frame(8'h1C, 0);
        send_frame(8'h23, 0);
        send_frame(8'hE0, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h1C, 0);
        check("ext_keeps_a_and_d", {W, A, S, D}, 4'b0101);

        // Release D, then a parity-corrupted 23 must not press it; a clean one does
        send_frame(8'hF0, 0);
        send_frame(8'h23, 0);
        send_frame(8'h23, 1);
        check("parity_err_d_low", D, 1'b0);
        send_frame(8'h23, 0);

        // Stop-bit error inside a break sequence drops the pending break
        send_frame(8'hF0, 0);
        send_frame(8'h55, 2);
        send_frame(8'h23, 0);
        check("stop_err_clears_break", D, 1'b1);

        // Partial frame of 5 bits, then bus goes quiet
        f = make_frame(8'h1B, 0);
        model_error();
        for (int i = 0; i < 4; i++) send_bit(f[i]);
        @(negedge clk) ps2_data = f[4];
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        cnt = 0;
        for (int k = 1; k <= T + 20; k++) begin
            @(negedge clk);
            if (frame_err) begin
                cnt = k;
                break;
            end
        end
        n_vec++;
        if (cnt < T + 2 || cnt > T + 4) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d cycles required %0d..%0d", cnt, T + 2, T + 4);
        end
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (8) @(negedge clk);
        send_frame(8'h1B, 0);

        // Reset mid-frame while W is held; the rest of the frame must not produce a code
        send_frame(8'h1D, 0);
        f = make_frame(8'hFF, 0);
        for (int i = 0; i < 3; i++) send_bit(f[i]);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check_idle_outputs("mid_reset");
        model_reset();
        for (int i = 3; i < 11; i++) send_bit(f[i]);
        repeat (10) @(negedge clk);

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            int c;
            b = pool[$urandom_range(0, 7)];
            c = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
            send_frame(b, c);
        end

        repeat (20) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("final_keys", {W, A, S, D}, m_keys);
        check("final_code", code, m_code);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
